text_console: RTL
=================

// Module: text_console
// PURPOSE
//  CPU-side writer for the 80x25 text video memory (memtext port A); the VGA text scanner reads port B.
//  Turns byte writes from the AVR I/O bus into char/attribute stores at the cursor.
//  Handles control codes (CR, LF, BS, FF), line wrap, hardware scroll-up and screen clear.
//  Exports the cursor position to the VGA block.
// PARAMETERS
//  COLS      80     characters per row
//  ROWS      25     rows per screen
//  ADDR_W    13     text memory byte-address width
//  DEF_ATTR  8'h07  attribute after reset
//  FILL_CHAR 8'h20  character used by scroll fill and clear
// PORTS
//  clock       in   1       system clock; memtext port A runs on this clock
//  reset       in   1       asynchronous, active-high
//  io_addr     in   2       0=PUTC 1=ATTR 2=CURX 3=CURY
//  io_data     in   8       write data
//  io_we       in   1       one-cycle write strobe
//  busy        out  1       memory operation in progress
//  mem_address out  ADDR_W  memtext address_a (byte address)
//  mem_data_o  out  8       memtext data_a
//  mem_wren    out  1       memtext wren_a
//  mem_data_i  in   8       memtext q_a; valid the cycle after the address is presented
//  cursor_x    out  7       current column, 0..COLS-1
//  cursor_y    out  5       current row, 0..ROWS-1
// BEHAVIOUR
//  Reset values
//   - busy=0, cursor_x=0, cursor_y=0, attr=DEF_ATTR
//   - mem_wren=0, mem_address=0, mem_data_o=0, state=IDLE
//  Memory map
//   - cell (x,y) at byte 2*(y*COLS+x): even byte=char, odd byte=attr
//  Acceptance
//   - io_we sampled only in IDLE with busy=0
//   - io_we while busy is dropped; no queue. Software polls busy.
//  ATTR / CURX / CURY
//   - take effect on the accepting edge; busy stays 0
//   - CURX>=COLS clamps to COLS-1; CURY>=ROWS clamps to ROWS-1
//  PUTC printable (any code except 08/0A/0C/0D)
//   - state PUT_C: write char to even byte. Next cycle PUT_A: write attr to odd byte.
//   - then x+1
//   - if x was COLS-1: x=0, y+1
//   - if y was ROWS-1: enter SCROLL instead of incrementing y
//   - busy=1 from the accepting edge until the return to IDLE
//  Control codes
//   - 0x0D CR: x=0, one cycle, no busy
//   - 0x0A LF: x=0; if y<ROWS-1 then y+1 (no busy), else SCROLL
//   - 0x08 BS: if x>0 then x-1, else no change; no erase
//   - 0x0C FF: CLEAR_ALL, then x=y=0
//  SCROLL (y stays ROWS-1)
//   - for each byte i in 0..2*COLS*(ROWS-1)-1:
//     - cycle 1 (SC_RD): address=i+2*COLS, wren=0
//     - cycle 2 (SC_WR): address=i, data=mem_data_i, wren=1
//   - then FILL over the last row: char bytes=FILL_CHAR, attr bytes=current attr, one byte/cycle
//   - 80x25 totals: 7680 copy cycles + 160 fill cycles
//  CLEAR_ALL
//   - FILL over all 2*COLS*ROWS bytes, one per cycle (4000 cycles)
//  Writes
//   - mem_wren is high only in PUT_C, PUT_A, SC_WR and FILL
//  Reset mid-operation
//   - aborts immediately; memory is left partially updated
//   - no further writes; all outputs return to reset values
//  Arithmetic
//   - addresses computed in ADDR_W bits
//   - y*COLS via shift-add (y<<6 + y<<4 for 80); no wrap past 2*COLS*ROWS-1
// STRUCTURE
//  Include text_console_defs.vh
//   - register indices, control-code constants, state encodings
//   - COLS/ROWS-derived byte counts
//  Sub-module text_blit: copy/fill engine
//   - inputs: start, mode(copy/fill), src, dst, len, fill char, attr
//   - owns SC_RD/SC_WR/FILL sequencing and the memory port while active
//   - reports done
//  text_console keeps the cursor, attr, decode FSM and the port mux.
// TESTING
//  1. Reset, PUTC 'A' -> writes 0x41 @0 then 0x07 @1 on consecutive cycles; cursor_x=1; busy 2 cycles.
//  2. ATTR=0x1F, CURX=79, CURY=3, PUTC 'Z' -> 0x5A @638, 0x1F @639; cursor (0,4).
//  3. CURY=24, LF with memory preloaded -> byte 160 copied to 0, byte 3999 copied to 3839.
//     Also: 3840..3999 = 20/attr pattern; 7840 busy cycles; cursor (0,24).
//  4. FF -> 4000 writes of 20/attr; cursor (0,0); io_we issued mid-clear is ignored.
//  5. BS at x=0 -> no change; CURX=200 -> cursor_x=79; CR -> x=0, busy never rises.
//  6. reset asserted mid-SCROLL -> mem_wren=0 that cycle; busy=0; cursor (0,0); attr=07.

Source files
------------

// File: rtl/text_console_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_pkg
//  Description : Shared constants and state types for the text console
//                writer and its copy/fill engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package text_console_pkg;

  // I/O register indices on the AVR bus
  localparam logic [1:0] REG_PUTC = 2'd0;
  localparam logic [1:0] REG_ATTR = 2'd1;
  localparam logic [1:0] REG_CURX = 2'd2;
  localparam logic [1:0] REG_CURY = 2'd3;

  // Control codes recognised by PUTC
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  // Console decode FSM
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PUT_C       = 3'd1,
    ST_PUT_A       = 3'd2,
    ST_SCROLL_COPY = 3'd3,
    ST_SCROLL_FILL = 3'd4,
    ST_CLEAR       = 3'd5
  } con_state_t;

  // Copy/fill engine sequencing
  typedef enum logic [1:0] {
    BL_IDLE  = 2'd0,
    BL_SC_RD = 2'd1,
    BL_SC_WR = 2'd2,
    BL_FILL  = 2'd3
  } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/text_blit.sv
`default_nettype none
// ============================================================================
//  Module      : text_blit
//  Description : Copy/fill engine for text memory. Copy moves len bytes
//                from src to dst with one read and one write cycle per
//                byte; fill writes len bytes starting at dst with the fill
//                character on even bytes and the attribute on odd bytes.
//                A new start is accepted on the final cycle of a run so
//                back-to-back operations have no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_blit
  import text_console_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,        // 0 = copy, 1 = fill
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,         // must be non-zero
  input  logic [7:0]        fill_char,
  input  logic [7:0]        attr,
  input  logic [7:0]        mem_data_i,
  output logic              active,
  output logic              last,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  blit_state_t       state;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] remaining;
  logic [7:0]        fill_data;
  logic [7:0]        char_r;
  logic [7:0]        attr_r;
  logic              wren_r;
  logic              accept;

  assign active      = (state != BL_IDLE);
  assign last        = ((state == BL_SC_WR) || (state == BL_FILL)) && (remaining == ADDR_ONE);
  assign accept      = start && ((state == BL_IDLE) || last);
  assign mem_wren    = wren_r;
  assign mem_address = addr_r;
  // Copy data comes straight from the RAM read port, which is valid in the
  // write cycle that follows the read address.
  assign mem_data_o  = (state == BL_SC_WR) ? mem_data_i : fill_data;

  // Engine sequencer: loads a run on start, then steps read/write or fill
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= BL_IDLE;
      addr_r    <= '0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_data <= '0;
      char_r    <= '0;
      attr_r    <= '0;
      wren_r    <= 1'b0;
    end else if (accept) begin
      remaining <= len;
      char_r    <= fill_char;
      attr_r    <= attr;
      if (mode) begin
        state     <= BL_FILL;
        addr_r    <= dst;
        wren_r    <= 1'b1;
        fill_data <= dst[0] ? attr : fill_char;
      end else begin
        state   <= BL_SC_RD;
        addr_r  <= src;
        wren_r  <= 1'b0;
        src_ptr <= src + ADDR_ONE;
        dst_ptr <= dst;
      end
    end else begin
      case (state)
        BL_SC_RD: begin
          state   <= BL_SC_WR;
          addr_r  <= dst_ptr;
          wren_r  <= 1'b1;
          dst_ptr <= dst_ptr + ADDR_ONE;
        end
        BL_SC_WR: begin
          if (last) begin
            state  <= BL_IDLE;
            wren_r <= 1'b0;
          end else begin
            state     <= BL_SC_RD;
            addr_r    <= src_ptr;
            wren_r    <= 1'b0;
            src_ptr   <= src_ptr + ADDR_ONE;
            remaining <= remaining - ADDR_ONE;
          end
        end
        BL_FILL: begin
          if (last) begin
            state  <= BL_IDLE;
            wren_r <= 1'b0;
          end else begin
            addr_r    <= addr_r + ADDR_ONE;
            // next byte flips parity: even address is followed by an attr byte
            fill_data <= addr_r[0] ? char_r : attr_r;
            remaining <= remaining - ADDR_ONE;
          end
        end
        default: begin
          state  <= BL_IDLE;
          wren_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
//  Module      : text_console
//  Description : CPU-side writer for the text video memory. Decodes byte
//                writes from the I/O bus into char/attr stores at the
//                cursor, handles CR/LF/BS/FF, line wrap, scroll-up and
//                screen clear, and exports the cursor position.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_console
  import text_console_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 25,
  parameter int         ADDR_W    = 13,
  parameter logic [7:0] DEF_ATTR  = 8'h07,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        io_addr,
  input  logic [7:0]        io_data,
  input  logic              io_we,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data_o,
  output logic              mem_wren,
  input  logic [7:0]        mem_data_i,
  output logic [6:0]        cursor_x,
  output logic [4:0]        cursor_y
);

  localparam logic [ADDR_W-1:0] ROW_BYTES    = ADDR_W'(2 * COLS);
  localparam logic [ADDR_W-1:0] COPY_BYTES   = ADDR_W'(2 * COLS * (ROWS - 1));
  localparam logic [ADDR_W-1:0] SCREEN_BYTES = ADDR_W'(2 * COLS * ROWS);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
  localparam logic [6:0]        LAST_X       = 7'(COLS - 1);
  localparam logic [4:0]        LAST_Y       = 5'(ROWS - 1);
  localparam logic [7:0]        COLS_B       = 8'(COLS);
  localparam logic [7:0]        ROWS_B       = 8'(ROWS);

  // Byte address of the char cell at (x,y); y*COLS is built from shifted
  // copies of y selected by the set bits of COLS (y<<6 + y<<4 for 80).
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 8; b++) begin
      if (((COLS >> b) & 1) == 1) acc = acc + (ADDR_W'(y) << b);
    end
    acc = acc + ADDR_W'(x);
    return acc << 1;
  endfunction

  con_state_t        state;
  logic [7:0]        attr;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        data_r;

  logic              accept_putc;
  logic              start_copy;
  logic              start_fill;
  logic              blit_start;
  logic [ADDR_W-1:0] blit_dst;
  logic [ADDR_W-1:0] blit_len;
  logic              blit_active;
  logic              blit_last;
  logic              blit_wren;
  logic [ADDR_W-1:0] blit_address;
  logic [7:0]        blit_data;

  // Engine launch: copy on a scroll request, fill for the vacated row or a
  // full clear; the row fill chains onto the last copy cycle.
  assign accept_putc = (state == ST_IDLE) && io_we && (io_addr == REG_PUTC);
  assign start_copy  = (accept_putc && (io_data == CC_LF) && (cursor_y == LAST_Y)) ||
                       ((state == ST_PUT_A) && (cursor_x == LAST_X) && (cursor_y == LAST_Y));
  assign start_fill  = (accept_putc && (io_data == CC_FF)) ||
                       ((state == ST_SCROLL_COPY) && blit_last);
  assign blit_start  = start_copy || start_fill;
  assign blit_dst    = (state == ST_SCROLL_COPY) ? COPY_BYTES : '0;
  assign blit_len    = start_copy ? COPY_BYTES :
                       ((state == ST_SCROLL_COPY) ? ROW_BYTES : SCREEN_BYTES);

  // The engine owns the memory port while it runs
  assign mem_wren    = blit_active ? blit_wren    : wr_r;
  assign mem_address = blit_active ? blit_address : addr_r;
  assign mem_data_o  = blit_active ? blit_data    : data_r;

  text_blit #(
    .ADDR_W (ADDR_W)
  ) u_blit (
    .clock       (clock),
    .reset       (reset),
    .start       (blit_start),
    .mode        (start_fill),
    .src         (ROW_BYTES),
    .dst         (blit_dst),
    .len         (blit_len),
    .fill_char   (FILL_CHAR),
    .attr        (attr),
    .mem_data_i  (mem_data_i),
    .active      (blit_active),
    .last        (blit_last),
    .mem_wren    (blit_wren),
    .mem_address (blit_address),
    .mem_data_o  (blit_data)
  );

  // Decode FSM: register writes, cursor movement, char/attr stores
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      cursor_x <= '0;
      cursor_y <= '0;
      attr     <= DEF_ATTR;
      wr_r     <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_we) begin
            case (io_addr)
              REG_ATTR: attr <= io_data;
              REG_CURX: cursor_x <= (io_data >= COLS_B) ? LAST_X : io_data[6:0];
              REG_CURY: cursor_y <= (io_data >= ROWS_B) ? LAST_Y : io_data[4:0];
              default: begin
                case (io_data)
                  CC_CR: cursor_x <= '0;
                  CC_LF: begin
                    cursor_x <= '0;
                    if (cursor_y == LAST_Y) begin
                      state <= ST_SCROLL_COPY;
                      busy  <= 1'b1;
                    end else begin
                      cursor_y <= cursor_y + 5'd1;
                    end
                  end
                  CC_BS: begin
                    if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
                  end
                  CC_FF: begin
                    state <= ST_CLEAR;
                    busy  <= 1'b1;
                  end
                  default: begin
                    state  <= ST_PUT_C;
                    busy   <= 1'b1;
                    wr_r   <= 1'b1;
                    addr_r <= cell_addr(cursor_x, cursor_y);
                    data_r <= io_data;
                  end
                endcase
              end
            endcase
          end
        end
        ST_PUT_C: begin
          state  <= ST_PUT_A;
          addr_r <= addr_r + ADDR_ONE;
          data_r <= attr;
        end
        ST_PUT_A: begin
          wr_r <= 1'b0;
          if (cursor_x == LAST_X) begin
            cursor_x <= '0;
            if (cursor_y == LAST_Y) begin
              state <= ST_SCROLL_COPY;
            end else begin
              cursor_y <= cursor_y + 5'd1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end
          end else begin
            cursor_x <= cursor_x + 7'd1;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end
        ST_SCROLL_COPY: begin
          if (blit_last) state <= ST_SCROLL_FILL;
        end
        ST_SCROLL_FILL: begin
          if (blit_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (blit_last) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            cursor_x <= '0;
            cursor_y <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          wr_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
